// File: rtl/ifetch_axi_master_if.sv
// Bundle of the fetch request, fetched-word stream, AXI AR channel and AXI R channel
// seen by ifetch_axi_master.
//   master modport: the fetch engine's view (drives req_ready, resp_*, AR*, RREADY_M).
//   slave modport : the surrounding environment's view (requester, consumer and AXI slave).
interface ifetch_axi_master_if;
  // Fetch request
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  // Fetched-word stream
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_last;
  logic        resp_err;
  // AXI read address channel
  logic [3:0]  ARID_M;
  logic [31:0] ARADDR_M;
  logic [3:0]  ARLEN_M;
  logic [2:0]  ARSIZE_M;
  logic [1:0]  ARBURST_M;
  logic        ARVALID_M;
  logic        ARREADY_M;
  // AXI read data channel
  logic [3:0]  RID_M;
  logic [31:0] RDATA_M;
  logic [1:0]  RRESP_M;
  logic        RLAST_M;
  logic        RVALID_M;
  logic        RREADY_M;

  modport master (
    input  req_valid, req_addr, req_len,
    output req_ready,
    output resp_valid, resp_data, resp_last, resp_err,
    input  resp_ready,
    output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
    input  ARREADY_M,
    input  RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    output RREADY_M
  );

  modport slave (
    output req_valid, req_addr, req_len,
    input  req_ready,
    input  resp_valid, resp_data, resp_last, resp_err,
    output resp_ready,
    input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
    output ARREADY_M,
    output RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    input  RREADY_M
  );
endinterface

// File: rtl/ifetch_axi_master.sv
// Instruction-fetch AXI read master. Accepts one fetch request (word address + beat count),
// issues a single INCR burst of 32-bit beats, checks each returned beat and buffers it in a
// small response FIFO that feeds the fetched-word stream.
// Ports:
//   clk  - clock, rising edge
//   rstn - synchronous active-low reset
//   bus  - ifetch_axi_master_if.master: req_*, resp_*, AXI AR and R channel signals
module ifetch_axi_master #(
  parameter logic [3:0]  MASTER_ID  = 4'd0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rstn,
  ifetch_axi_master_if.master bus
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e state_q, state_d;

  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic [3:0]  arlen_q;
  logic [2:0]  arsize_q;
  logic [1:0]  arburst_q;
  logic [3:0]  beat_cnt_q;

  logic [31:0] data_mem [FIFO_DEPTH];
  logic        last_mem [FIFO_DEPTH];
  logic        err_mem  [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;

  logic req_hs, ar_hs, push, pop, full, empty, beat_err;

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  assign req_hs = bus.req_valid && (state_q == StIdle);
  assign ar_hs  = bus.ARREADY_M && (state_q == StAddr);
  assign push   = bus.RVALID_M && bus.RREADY_M;
  assign pop    = !empty && bus.resp_ready;

  // Beat is flagged when the slave reports an error, answers for another ID, or its
  // RLAST does not line up with the length we asked for.
  assign beat_err = (bus.RRESP_M != 2'b00) || (bus.RID_M != MASTER_ID) ||
                    (bus.RLAST_M != (beat_cnt_q == arlen_q));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.req_valid) state_d = StAddr;
      StAddr: if (bus.ARREADY_M) state_d = StData;
      StData: if (push && bus.RLAST_M) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // AR fields are captured once at request acceptance and held through the ADDR phase.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else if (req_hs) begin
      arid_q    <= MASTER_ID;
      araddr_q  <= {bus.req_addr[31:2], 2'b00};
      arlen_q   <= bus.req_len;
      arsize_q  <= 3'b010;
      arburst_q <= 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      beat_cnt_q <= '0;
    end else if (ar_hs) begin
      beat_cnt_q <= '0;
    end else if (push) begin
      beat_cnt_q <= beat_cnt_q + 4'd1;
    end
  end

  // FIFO storage needs no reset: nothing is visible while occupancy is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= bus.RDATA_M;
      last_mem[wr_ptr_q] <= bus.RLAST_M;
      err_mem[wr_ptr_q]  <= beat_err;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_comb begin
    bus.req_ready  = (state_q == StIdle);
    bus.ARVALID_M  = (state_q == StAddr);
    bus.ARID_M     = arid_q;
    bus.ARADDR_M   = araddr_q;
    bus.ARLEN_M    = arlen_q;
    bus.ARSIZE_M   = arsize_q;
    bus.ARBURST_M  = arburst_q;
    bus.RREADY_M   = (state_q == StData) && !full;
    bus.resp_valid = !empty;
    // Stale FIFO contents are masked so the stream reads as zero when empty.
    bus.resp_data  = empty ? 32'd0 : data_mem[rd_ptr_q];
    bus.resp_last  = empty ? 1'b0  : last_mem[rd_ptr_q];
    bus.resp_err   = empty ? 1'b0  : err_mem[rd_ptr_q];
  end

endmodule

// File: tb/tb_ifetch_axi_master.sv
module tb_ifetch_axi_master;
  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  ifetch_axi_master_if bus ();

  ifetch_axi_master #(
    .MASTER_ID  (4'd0),
    .FIFO_DEPTH (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [31:0] addr, input logic [3:0] len,
                         input logic [31:0] exp_araddr);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_len   = len;
    tick();
    bus.req_valid = 1'b0;
    chk("arvalid_addr", bus.ARVALID_M, 1);
    chk("araddr", bus.ARADDR_M, exp_araddr);
    chk("arlen", bus.ARLEN_M, len);
    chk("arsize", bus.ARSIZE_M, 3'b010);
    chk("arburst", bus.ARBURST_M, 2'b01);
    chk("arid", bus.ARID_M, 4'd0);
    chk("req_ready_busy", bus.req_ready, 0);
  endtask

  task automatic ar_accept();
    bus.ARREADY_M = 1'b1;
    tick();
    bus.ARREADY_M = 1'b0;
    chk("arvalid_data", bus.ARVALID_M, 0);
    chk("rready_data", bus.RREADY_M, 1);
  endtask

  task automatic send_beat(input logic [31:0] data, input logic [1:0] resp,
                           input logic [3:0] id, input logic last);
    int  n;
    logic ok;
    ok = 1'b0;
    n  = 0;
    bus.RVALID_M = 1'b1;
    bus.RDATA_M  = data;
    bus.RRESP_M  = resp;
    bus.RID_M    = id;
    bus.RLAST_M  = last;
    while (!ok && n < 20) begin
      if (bus.RREADY_M === 1'b1) ok = 1'b1;
      tick();
      n++;
    end
    bus.RVALID_M = 1'b0;
    bus.RLAST_M  = 1'b0;
    bus.RRESP_M  = 2'b00;
    bus.RID_M    = 4'd0;
    chk("r_handshake_timeout", ok, 1);
  endtask

  task automatic pop_check(input logic [31:0] data, input logic last, input logic err);
    chk("resp_valid", bus.resp_valid, 1);
    chk("resp_data", bus.resp_data, data);
    chk("resp_last", bus.resp_last, last);
    chk("resp_err", bus.resp_err, err);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rstn           = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_len    = '0;
    bus.resp_ready = 1'b0;
    bus.ARREADY_M  = 1'b0;
    bus.RID_M      = '0;
    bus.RDATA_M    = '0;
    bus.RRESP_M    = '0;
    bus.RLAST_M    = 1'b0;
    bus.RVALID_M   = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_arvalid", bus.ARVALID_M, 0);
    chk("rst_rready", bus.RREADY_M, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_resp_last", bus.resp_last, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    chk("rst_araddr", bus.ARADDR_M, 0);
    chk("rst_arlen", bus.ARLEN_M, 0);
    rstn = 1'b1;
    tick();

    // Single fetch, ARREADY delayed two cycles
    request(32'h0000_0104, 4'd0, 32'h0000_0104);
    tick();
    chk("t1_arvalid_hold", bus.ARVALID_M, 1);
    chk("t1_araddr_hold", bus.ARADDR_M, 32'h0000_0104);
    ar_accept();
    chk("t1_no_early_resp", bus.resp_valid, 0);
    send_beat(32'hDEAD_BEEF, 2'b00, 4'd0, 1'b1);
    chk("t1_idle_again", bus.req_ready, 1);
    chk("t1_rready_idle", bus.RREADY_M, 0);
    pop_check(32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("t1_empty", bus.resp_valid, 0);

    // Early RLAST on beat 1 of 4
    request(32'h0000_0180, 4'd3, 32'h0000_0180);
    ar_accept();
    send_beat(32'h1111_1111, 2'b00, 4'd0, 1'b1);
    chk("t5_idle", bus.req_ready, 1);
    chk("t5_rready", bus.RREADY_M, 0);
    pop_check(32'h1111_1111, 1'b1, 1'b1);

    // Unaligned 8-beat burst with consumer backpressure
    request(32'h0000_0107, 4'd7, 32'h0000_0104);
    ar_accept();
    for (int i = 0; i < 4; i++) send_beat(32'h1000 + i, 2'b00, 4'd0, 1'b0);
    chk("t2_full_rready", bus.RREADY_M, 0);
    chk("t2_full_valid", bus.resp_valid, 1);
    bus.RVALID_M = 1'b1;
    bus.RDATA_M  = 32'h0000_1004;
    tick();
    tick();
    chk("t2_blocked_rready", bus.RREADY_M, 0);
    chk("t2_head_stable", bus.resp_data, 32'h0000_1000);
    bus.RVALID_M = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pop_check(32'h1000 + i, 1'b0, 1'b0);
      send_beat(32'h1004 + i, 2'b00, 4'd0, (i == 3));
    end
    for (int i = 4; i < 8; i++) pop_check(32'h1000 + i, (i == 7), 1'b0);
    chk("t2_drained", bus.resp_valid, 0);
    chk("t2_idle", bus.req_ready, 1);

    // RRESP error on beat 2 of 4, consumer always ready (push and pop together)
    request(32'h0000_0200, 4'd3, 32'h0000_0200);
    ar_accept();
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_rready", bus.RREADY_M, 1);
      bus.RVALID_M = 1'b1;
      bus.RDATA_M  = 32'hA0 + i;
      bus.RRESP_M  = (i == 1) ? 2'b11 : 2'b00;
      bus.RLAST_M  = (i == 3);
      tick();
      chk("t3_valid", bus.resp_valid, 1);
      chk("t3_data", bus.resp_data, 32'hA0 + i);
      chk("t3_err", bus.resp_err, (i == 1));
      chk("t3_last", bus.resp_last, (i == 3));
    end
    bus.RVALID_M = 1'b0;
    bus.RLAST_M  = 1'b0;
    bus.RRESP_M  = 2'b00;
    chk("t3_idle", bus.req_ready, 1);
    tick();
    bus.resp_ready = 1'b0;
    chk("t3_empty", bus.resp_valid, 0);

    // Second request accepted while a beat is still buffered; wrong RID on it
    request(32'h0000_0400, 4'd0, 32'h0000_0400);
    ar_accept();
    send_beat(32'h4444_0000, 2'b00, 4'd0, 1'b1);
    chk("t4_buffered", bus.resp_valid, 1);
    request(32'h0000_0404, 4'd0, 32'h0000_0404);
    ar_accept();
    send_beat(32'h5555_0000, 2'b00, 4'hF, 1'b1);
    pop_check(32'h4444_0000, 1'b1, 1'b0);
    pop_check(32'h5555_0000, 1'b1, 1'b1);

    // Reset mid-burst
    request(32'h0000_0500, 4'd3, 32'h0000_0500);
    ar_accept();
    send_beat(32'h0000_5000, 2'b00, 4'd0, 1'b0);
    send_beat(32'h0000_5001, 2'b00, 4'd0, 1'b0);
    rstn = 1'b0;
    tick();
    chk("t6_resp_valid", bus.resp_valid, 0);
    chk("t6_rready", bus.RREADY_M, 0);
    chk("t6_req_ready", bus.req_ready, 1);
    chk("t6_arvalid", bus.ARVALID_M, 0);
    chk("t6_araddr", bus.ARADDR_M, 0);
    chk("t6_resp_data", bus.resp_data, 0);
    rstn = 1'b1;
    bus.RVALID_M = 1'b1;
    bus.RDATA_M  = 32'h0000_0BAD;
    tick();
    chk("t6_stray_rready", bus.RREADY_M, 0);
    chk("t6_stray_valid", bus.resp_valid, 0);
    bus.RVALID_M = 1'b0;
    request(32'h0000_0600, 4'd0, 32'h0000_0600);
    ar_accept();
    send_beat(32'h6666_6666, 2'b00, 4'd0, 1'b1);
    pop_check(32'h6666_6666, 1'b1, 1'b0);
    chk("t6_final_empty", bus.resp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_axi_master.md
IFETCH_AXI_MASTER -- requirements
Module: ifetch_axi_master

Interface
REQ-001 SHALL have parameter MASTER_ID, default 4'd0, the constant ARID driven on every read.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the response FIFO depth in beats (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1 bit, the clock; all state changes on the rising edge.
REQ-004 SHALL have port rstn, input, 1 bit, the reset: synchronous, active-low.
REQ-005 SHALL have ports req_valid/req_ready: input/output, 1 bit each, the fetch request handshake.
REQ-006 SHALL have ports req_addr, input, 32 bits (byte address), and req_len, input, 4 bits (beats minus 1).
REQ-007 SHALL have ports resp_valid (output, 1), resp_ready (input, 1), resp_data (output, 32), resp_last (output, 1) and resp_err (output, 1), forming the fetched-word stream.
REQ-008 SHALL have AR outputs ARID_M[3:0], ARADDR_M[31:0], ARLEN_M[3:0], ARSIZE_M[2:0], ARBURST_M[1:0], ARVALID_M, and input ARREADY_M.
REQ-009 SHALL have R inputs RID_M[3:0], RDATA_M[31:0], RRESP_M[1:0], RLAST_M, RVALID_M, and output RREADY_M.

Function
REQ-010 SHALL implement FSM states IDLE, ADDR, DATA.
REQ-011 SHALL hold req_ready=1 only in IDLE; a request is accepted on req_valid&req_ready, moving to ADDR next cycle.
REQ-012 SHALL register on acceptance: ARADDR_M={req_addr[31:2],2'b00}, ARLEN_M=req_len, ARSIZE_M=3'b010, ARBURST_M=2'b01 (INCR), ARID_M=MASTER_ID.
REQ-013 SHALL hold ARVALID_M=1 in ADDR with all AR fields stable until ARREADY_M; the handshake moves to DATA next cycle.
REQ-014 SHALL ignore ARREADY_M outside ADDR; ARVALID_M SHALL be 0 in IDLE and DATA.
REQ-015 SHALL drive RREADY_M=1 only in DATA and only while the FIFO is not full.
REQ-016 SHALL push {RDATA_M, last, err} into the FIFO on each R handshake.
REQ-017 SHALL count R beats in a 4-bit counter cleared on AR handshake; last = RLAST_M.
REQ-018 SHALL set err=1 on a beat if any of these hold:
  - RRESP_M != 2'b00
  - RID_M != MASTER_ID
  - RLAST_M disagrees with (beat counter == ARLEN_M)
REQ-019 SHALL return to IDLE the cycle after an R handshake with RLAST_M=1, regardless of the beat count.
REQ-020 SHALL drive resp_valid = FIFO not empty; resp_data, resp_last and resp_err come from the FIFO head; pop on resp_valid&resp_ready.
REQ-021 SHALL hold resp_* stable while resp_valid=1 and resp_ready=0.
REQ-022 SHALL, on simultaneous push and pop, apply both in the same cycle with occupancy unchanged.
REQ-023 SHALL, when the FIFO is full, block the push via RREADY_M=0, with no bypass path.
REQ-024 SHALL let FIFO pointers wrap modulo FIFO_DEPTH, with occupancy held in a separate counter from 0 to FIFO_DEPTH.
REQ-025 SHALL allow a new request to be accepted in IDLE while earlier beats remain in the FIFO; ordering is preserved.
REQ-026 SHALL add a one-cycle minimum latency from R handshake to resp_valid; there is no combinational R-to-resp path.

Reset
REQ-027 SHALL, while rstn=0 at a clock edge, set state=IDLE, empty the FIFO, clear the beat counter, and clear all AR registers to 0.
REQ-028 SHALL show these output values after reset: req_ready=1, ARVALID_M=0, RREADY_M=0, resp_valid=0, resp_data=0, resp_last=0, resp_err=0, ARADDR_M=0, ARLEN_M=0.
REQ-029 SHALL, on reset mid-burst, drop all in-flight and buffered beats; any R beats the slave sends after reset are not accepted, because RREADY_M=0 in IDLE.

Verification
REQ-030 Single fetch: req_addr=0x0000_0104, req_len=0; ARREADY after 2 cycles -> ARADDR_M=0x104, ARLEN_M=0 observed; one beat RLAST=1 with data 0xDEADBEEF -> resp_data=0xDEADBEEF, resp_last=1, resp_err=0; FSM back in IDLE.
REQ-031 Burst with backpressure: req_len=7, resp_ready=0 throughout -> exactly 4 beats accepted, then RREADY_M=0; raising resp_ready drains all 8 beats in order with resp_last only on beat 8.
REQ-032 Unaligned address: req_addr=0x0000_0107 -> ARADDR_M=0x0000_0104.
REQ-033 Error beats:
  - RRESP_M=2'b11 on beat 2 of 4 -> resp_err=1 on that beat only.
  - RID_M=4'hF -> resp_err=1.
  - RLAST_M=1 on beat 1 of req_len=3 -> resp_err=1, resp_last=1, return to IDLE.
REQ-034 Reset mid-burst: rstn=0 after 2 of 4 beats -> next cycle resp_valid=0, RREADY_M=0, req_ready=1; a new request then completes normally.
